// File: rtl/sm2_ladder_ctrl.sv
// Montgomery-ladder sequencer for SM2 scalar multiplication in X/Z coordinates.
// The sequencer scans k from its MSB to find the leading one. It then drives the
// point-doubling (PD) and differential point-addition (PA) units once per ladder bit.
// It returns R0=[k]P and R1=[k+1]P. This block does no field arithmetic.
module sm2_ladder_ctrl #(
  parameter int NBITS = 256,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] k,
  input  logic [255:0]     xp,
  output logic             busy,
  output logic             done,
  output logic [255:0]     x0,
  output logic [255:0]     z0,
  output logic [255:0]     x1,
  output logic [255:0]     z1,
  output logic             pd_run_n,
  output logic [255:0]     pd_x,
  output logic [255:0]     pd_z,
  input  logic [255:0]     pd_xo,
  input  logic [255:0]     pd_zo,
  input  logic             pd_done,
  output logic             pa_run_n,
  output logic [255:0]     pa_x1,
  output logic [255:0]     pa_z1,
  output logic [255:0]     pa_x2,
  output logic [255:0]     pa_z2,
  output logic [255:0]     pa_xd,
  input  logic [255:0]     pa_xo,
  input  logic [255:0]     pa_zo,
  input  logic             pa_done
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [255:0]  ONE      = 256'd1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_INIT, S_STEP, S_GAP, S_FIN} state_t;

  state_t state_reg, state_next;

  logic [NBITS-1:0] k_reg;
  logic [255:0]     xp_reg;
  logic [IW-1:0]    idx_reg;
  logic [GW-1:0]    gap_cnt_reg;
  logic             bit_reg;
  logic             busy_reg, done_reg;
  logic [255:0]     r0x_reg, r0z_reg, r1x_reg, r1z_reg;
  logic [255:0]     x0_reg, z0_reg, x1_reg, z1_reg;
  logic             pd_run_reg, pa_run_reg;
  logic [255:0]     pd_x_reg, pd_z_reg;
  logic [255:0]     pa_x1_reg, pa_z1_reg, pa_x2_reg, pa_z2_reg;
  logic             pd_got_reg, pa_got_reg;
  logic [255:0]     pd_cx_reg, pd_cz_reg, pa_cx_reg, pa_cz_reg;

  logic             idx_bit, idx_zero, gap_end;
  logic             pd_ok, pa_ok, pd_have, pa_have;
  logic [255:0]     pd_rx, pd_rz, pa_rx, pa_rz;

  // A unit's done flag counts only while that unit is enabled. Once captured, a result
  // comes from the sticky copy. Before capture, it comes straight from the unit.
  assign idx_bit  = k_reg[idx_reg];
  assign idx_zero = (idx_reg == '0);
  assign gap_end  = (gap_cnt_reg == GAP_LAST);
  assign pd_ok    = pd_run_reg & pd_done;
  assign pa_ok    = pa_run_reg & pa_done;
  assign pd_have  = pd_got_reg | pd_ok;
  assign pa_have  = pa_got_reg | pa_ok;
  assign pd_rx    = pd_got_reg ? pd_cx_reg : pd_xo;
  assign pd_rz    = pd_got_reg ? pd_cz_reg : pd_zo;
  assign pa_rx    = pa_got_reg ? pa_cx_reg : pa_xo;
  assign pa_rz    = pa_got_reg ? pa_cz_reg : pa_zo;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign x0       = x0_reg;
  assign z0       = z0_reg;
  assign x1       = x1_reg;
  assign z1       = z1_reg;
  assign pd_run_n = pd_run_reg;
  assign pd_x     = pd_x_reg;
  assign pd_z     = pd_z_reg;
  assign pa_run_n = pa_run_reg;
  assign pa_x1    = pa_x1_reg;
  assign pa_z1    = pa_z1_reg;
  assign pa_x2    = pa_x2_reg;
  assign pa_z2    = pa_z2_reg;
  assign pa_xd    = xp_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: scan to the leading one, then an INIT doubling, then alternating GAP/STEP
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_SCAN;
      S_SCAN: begin
        if (idx_bit)       state_next = S_INIT;
        else if (idx_zero) state_next = S_FIN;
      end
      S_INIT: if (pd_ok) state_next = idx_zero ? S_FIN : S_GAP;
      S_GAP:  if (gap_end) state_next = S_STEP;
      S_STEP: if (pd_have && pa_have) state_next = idx_zero ? S_FIN : S_GAP;
      S_FIN:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand loading, result capture, ladder registers and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg       <= '0;
      xp_reg      <= '0;
      idx_reg     <= '0;
      gap_cnt_reg <= '0;
      bit_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      r0x_reg     <= '0;
      r0z_reg     <= '0;
      r1x_reg     <= '0;
      r1z_reg     <= '0;
      x0_reg      <= '0;
      z0_reg      <= '0;
      x1_reg      <= '0;
      z1_reg      <= '0;
      pd_run_reg  <= 1'b0;
      pa_run_reg  <= 1'b0;
      pd_x_reg    <= '0;
      pd_z_reg    <= '0;
      pa_x1_reg   <= '0;
      pa_z1_reg   <= '0;
      pa_x2_reg   <= '0;
      pa_z2_reg   <= '0;
      pd_got_reg  <= 1'b0;
      pa_got_reg  <= 1'b0;
      pd_cx_reg   <= '0;
      pd_cz_reg   <= '0;
      pa_cx_reg   <= '0;
      pa_cz_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            k_reg    <= k;
            xp_reg   <= xp;
            idx_reg  <= IDX_TOP;
            busy_reg <= 1'b1;
          end
        end
        S_SCAN: begin
          if (idx_bit) begin
            r0x_reg    <= xp_reg;
            r0z_reg    <= ONE;
            pd_x_reg   <= xp_reg;
            pd_z_reg   <= ONE;
            pd_run_reg <= 1'b1;
          end else if (idx_zero) begin
            r0x_reg <= ONE;      // k = 0: R0 is the point at infinity (1:0)
            r0z_reg <= '0;
            r1x_reg <= xp_reg;
            r1z_reg <= ONE;
          end else begin
            idx_reg <= idx_reg - IW'(1);
          end
        end
        S_INIT: begin
          if (pd_ok) begin
            r1x_reg     <= pd_xo;
            r1z_reg     <= pd_zo;
            pd_run_reg  <= 1'b0;
            gap_cnt_reg <= '0;
            if (!idx_zero) idx_reg <= idx_reg - IW'(1);
          end
        end
        S_GAP: begin
          if (gap_end) begin
            bit_reg    <= idx_bit;
            pa_x1_reg  <= r0x_reg;
            pa_z1_reg  <= r0z_reg;
            pa_x2_reg  <= r1x_reg;
            pa_z2_reg  <= r1z_reg;
            pd_x_reg   <= idx_bit ? r1x_reg : r0x_reg;
            pd_z_reg   <= idx_bit ? r1z_reg : r0z_reg;
            pd_run_reg <= 1'b1;
            pa_run_reg <= 1'b1;
            pd_got_reg <= 1'b0;
            pa_got_reg <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end
        S_STEP: begin
          if (pd_ok && !pd_got_reg) begin
            pd_cx_reg  <= pd_xo;
            pd_cz_reg  <= pd_zo;
            pd_got_reg <= 1'b1;
          end
          if (pa_ok && !pa_got_reg) begin
            pa_cx_reg  <= pa_xo;
            pa_cz_reg  <= pa_zo;
            pa_got_reg <= 1'b1;
          end
          if (pd_have && pa_have) begin
            if (bit_reg) begin
              r0x_reg <= pa_rx;
              r0z_reg <= pa_rz;
              r1x_reg <= pd_rx;
              r1z_reg <= pd_rz;
            end else begin
              r0x_reg <= pd_rx;
              r0z_reg <= pd_rz;
              r1x_reg <= pa_rx;
              r1z_reg <= pa_rz;
            end
            pd_run_reg  <= 1'b0;
            pa_run_reg  <= 1'b0;
            gap_cnt_reg <= '0;
            if (!idx_zero) idx_reg <= idx_reg - IW'(1);
          end
        end
        S_FIN: begin
          x0_reg   <= r0x_reg;
          z0_reg   <= r0z_reg;
          x1_reg   <= r1x_reg;
          z1_reg   <= r1z_reg;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm2_ladder_ctrl.sv
// Directed bench for sm2_ladder_ctrl. The PD and PA units are symbolic stubs.
// PD returns (2x, z) and PA returns (x1 + x2, z1), with a configurable or random latency.
// With these stubs, a correct ladder ends with x0 = k*xp and x1 = (k+1)*xp (mod 2^256).
// For k >= 1, both z values are 1.
module tb_sm2_ladder_ctrl;

  localparam int NBITS = 256;
  localparam int GAP   = 2;
  localparam logic [255:0] GX  = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [255:0] NSM = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123;
  localparam logic [255:0] JUNK = 256'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [NBITS-1:0] k;
  logic [255:0] xp;
  logic busy, done;
  logic [255:0] x0, z0, x1, z1;
  logic pd_run_n, pa_run_n;
  logic [255:0] pd_x, pd_z, pd_xo, pd_zo;
  logic [255:0] pa_x1, pa_z1, pa_x2, pa_z2, pa_xd, pa_xo, pa_zo;
  logic pd_done = 1'b0, pa_done = 1'b0;

  int checks = 0, errors = 0;
  int rand_mode = 0, pd_lat_cfg = 3, pa_lat_cfg = 3;
  int pd_cnt = 0, pa_cnt = 0, pd_cur = 1, pa_cur = 1;
  logic [255:0] xp_exp = '0;

  // cumulative monitor counters (written only by the monitor)
  int busy_cycles = 0, done_cycles = 0, pd_rises = 0, pa_rises = 0;
  int gap_viol = 0, xd_viol = 0, out_viol = 0, pd_low = 1000, pa_low = 1000;
  logic pd_prev = 1'b0, pa_prev = 1'b0;
  logic [1023:0] prev_out = '0;

  always #5 clk = ~clk;

  sm2_ladder_ctrl #(.NBITS(NBITS), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .xp(xp),
    .busy(busy), .done(done), .x0(x0), .z0(z0), .x1(x1), .z1(z1),
    .pd_run_n(pd_run_n), .pd_x(pd_x), .pd_z(pd_z),
    .pd_xo(pd_xo), .pd_zo(pd_zo), .pd_done(pd_done),
    .pa_run_n(pa_run_n), .pa_x1(pa_x1), .pa_z1(pa_z1), .pa_x2(pa_x2), .pa_z2(pa_z2),
    .pa_xd(pa_xd), .pa_xo(pa_xo), .pa_zo(pa_zo), .pa_done(pa_done)
  );

  // result buses carry junk until the stub reports done
  assign pd_xo = pd_done ? (pd_x << 1) : JUNK;
  assign pd_zo = pd_done ? pd_z : JUNK;
  assign pa_xo = pa_done ? (pa_x1 + pa_x2) : JUNK;
  assign pa_zo = pa_done ? pa_z1 : JUNK;

  // PD stub: done rises after its latency and holds until run_n is seen low
  always @(posedge clk) begin
    if (!pd_run_n) begin
      pd_cnt  <= 0;
      pd_done <= 1'b0;
    end else begin
      if (pd_cnt == 0) pd_cur = (rand_mode != 0) ? int'($urandom_range(40, 1)) : pd_lat_cfg;
      pd_cnt <= pd_cnt + 1;
      if (pd_cnt + 1 >= pd_cur) pd_done <= 1'b1;
    end
  end

  // PA stub: same protocol as the PD stub
  always @(posedge clk) begin
    if (!pa_run_n) begin
      pa_cnt  <= 0;
      pa_done <= 1'b0;
    end else begin
      if (pa_cnt == 0) pa_cur = (rand_mode != 0) ? int'($urandom_range(40, 1)) : pa_lat_cfg;
      pa_cnt <= pa_cnt + 1;
      if (pa_cnt + 1 >= pa_cur) pa_done <= 1'b1;
    end
  end

  // Protocol monitor: run counts, low time between runs, difference-x, output hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cycles++;
      if (done) done_cycles++;
      if (busy && done) out_viol++;
      if (pd_run_n && !pd_prev) begin
        pd_rises++;
        if (pd_low < GAP) gap_viol++;
      end
      if (pa_run_n && !pa_prev) begin
        pa_rises++;
        if (pa_low < GAP) gap_viol++;
      end
      pd_low = pd_run_n ? 0 : pd_low + 1;
      pa_low = pa_run_n ? 0 : pa_low + 1;
      if (pa_run_n && pa_xd !== xp_exp) xd_viol++;
      if (!done && {x0, z0, x1, z1} !== prev_out) out_viol++;
    end else begin
      pd_low = 1000;
      pa_low = 1000;
    end
    pd_prev  = pd_run_n;
    pa_prev  = pa_run_n;
    prev_out = {x0, z0, x1, z1};
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [255:0] kk, input logic [255:0] xx);
    @(negedge clk);
    k = kk; xp = xx; xp_exp = xx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", {255'd0, seen}, 256'd1);
    @(negedge clk);
    $display("op k=%0h : x0=%0h z0=%0h x1=%0h z1=%0h", k, x0, z0, x1, z1);
  endtask

  // run one ladder op and check results plus run counts
  task automatic ladder(input string tag, input logic [255:0] kk, input int pd_exp, input int pa_exp,
                        input int budget);
    int s_pd, s_pa, s_gap, s_xd, s_out, s_done;
    s_pd = pd_rises; s_pa = pa_rises; s_gap = gap_viol; s_xd = xd_viol;
    s_out = out_viol; s_done = done_cycles;
    start_op(kk, GX);
    wait_done(budget);
    check({tag, "_x0"}, x0, kk * GX);
    check({tag, "_x1"}, x1, (kk + 256'd1) * GX);
    check({tag, "_z0"}, z0, 256'd1);
    check({tag, "_z1"}, z1, 256'd1);
    check({tag, "_pd_runs"}, 256'(pd_rises - s_pd), 256'(pd_exp));
    check({tag, "_pa_runs"}, 256'(pa_rises - s_pa), 256'(pa_exp));
    check({tag, "_gap_viol"}, 256'(gap_viol - s_gap), 256'd0);
    check({tag, "_xd_viol"}, 256'(xd_viol - s_xd), 256'd0);
    check({tag, "_out_viol"}, 256'(out_viol - s_out), 256'd0);
    check({tag, "_done_len"}, 256'(done_cycles - s_done), 256'd1);
  endtask

  initial begin
    int s_busy, s_pd, s_pa, s_done;
    logic reached;
    rst_n = 1'b0; start = 1'b0; k = '0; xp = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_done", {255'd0, done}, 256'd0);
    check("rst_x0", x0, 256'd0);
    check("rst_z1", z1, 256'd0);
    check("rst_pd_run_n", {255'd0, pd_run_n}, 256'd0);
    check("rst_pa_run_n", {255'd0, pa_run_n}, 256'd0);
    check("rst_pd_x", pd_x, 256'd0);
    check("rst_pa_x1", pa_x1, 256'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // k = 0: pure scan, infinity in R0, no unit runs; busy for NBITS scan + FIN cycles
    s_busy = busy_cycles; s_pd = pd_rises; s_pa = pa_rises; s_done = done_cycles;
    start_op(256'd0, GX);
    wait_done(2000);
    check("k0_x0", x0, 256'd1);
    check("k0_z0", z0, 256'd0);
    check("k0_x1", x1, GX);
    check("k0_z1", z1, 256'd1);
    check("k0_pd_runs", 256'(pd_rises - s_pd), 256'd0);
    check("k0_pa_runs", 256'(pa_rises - s_pa), 256'd0);
    check("k0_busy_cycles", 256'(busy_cycles - s_busy), 256'(NBITS + 1));
    check("k0_done_len", 256'(done_cycles - s_done), 256'd1);

    // small scalars, fixed latency 3
    ladder("k1", 256'd1, 1, 0, 2000);
    ladder("k3", 256'd3, 2, 1, 2000);
    ladder("k2", 256'd2, 2, 1, 2000);

    // PA finishing before, after and together with PD
    pd_lat_cfg = 10; pa_lat_cfg = 5;
    ladder("pa_early", 256'hB5, 8, 7, 3000);
    pd_lat_cfg = 10; pa_lat_cfg = 15;
    ladder("pa_late", 256'hB5, 8, 7, 3000);
    pd_lat_cfg = 10; pa_lat_cfg = 10;
    ladder("pa_same", 256'hB5, 8, 7, 3000);

    // k = n-1 with random unit latencies 1..40
    rand_mode = 1;
    ladder("k_nm1", NSM - 256'd1, 256, 255, 20000);
    rand_mode = 0; pd_lat_cfg = 3; pa_lat_cfg = 3;

    // start pulsed mid-operation must be ignored
    s_done = done_cycles;
    start_op(256'd5, GX);
    repeat (20) @(negedge clk);
    k = 256'd7; xp = ~GX; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    check("busy_start_x0", x0, 256'd5 * GX);
    check("busy_start_x1", x1, 256'd6 * GX);
    check("busy_start_done_len", 256'(done_cycles - s_done), 256'd1);

    // asynchronous reset at ladder step 100
    rand_mode = 1;
    s_pd = pd_rises;
    start_op(NSM - 256'd1, GX);
    reached = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (pd_rises - s_pd >= 100) begin reached = 1'b1; break; end
    end
    check("rst_mid_reached", {255'd0, reached}, 256'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {255'd0, busy}, 256'd0);
    check("rst_mid_done", {255'd0, done}, 256'd0);
    check("rst_mid_x0", x0, 256'd0);
    check("rst_mid_z0", z0, 256'd0);
    check("rst_mid_x1", x1, 256'd0);
    check("rst_mid_z1", z1, 256'd0);
    check("rst_mid_pd_run_n", {255'd0, pd_run_n}, 256'd0);
    check("rst_mid_pa_run_n", {255'd0, pa_run_n}, 256'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s_pd = pd_rises;
    repeat (20) @(negedge clk);
    check("post_rst_idle_busy", {255'd0, busy}, 256'd0);
    check("post_rst_no_runs", 256'(pd_rises - s_pd), 256'd0);
    rand_mode = 0;

    // normal operation after the abort
    ladder("after_rst", 256'd2, 2, 1, 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
